fpga_input_debounce: RTL

Synchronises and debounces asynchronous board inputs (slide switches for GPIO and fetch enable, push buttons) before they reach the SoC on the Arty A7 FPGA top level. Each channel passes through a flip-flop synchroniser, then a consecutive-cycle stability filter. The block produces a clean level per channel plus single-cycle rise and fall pulses. It sits between the board pins and the SoC `fetch_en_i`/`gpio_i` inputs, in the `soc_clk` (20 MHz) domain.

---
 rtl/fpga_input_debounce.sv | 87 ++++++++
 1 files changed

// File: rtl/fpga_input_debounce.sv
// rtl/fpga_input_debounce.sv - per-channel synchroniser, stability filter and edge pulses
// Board switches/buttons enter raw and asynchronous; stable_o and the pulses are soc_clk clean.
module fpga_input_debounce #(
  parameter int                   NumInputs      = 5,
  parameter int                   SyncStages     = 2,
  parameter int                   DebounceCycles = 20000,
  parameter logic [NumInputs-1:0] ResetValue     = '0
) (
  input  logic                 soc_clk,
  input  logic                 rst_n,
  input  logic [NumInputs-1:0] raw_i,
  input  logic                 bypass_i,
  output logic [NumInputs-1:0] stable_o,
  output logic [NumInputs-1:0] rise_o,
  output logic [NumInputs-1:0] fall_o,
  output logic                 changed_o
);

  localparam int                   CntWidth = $clog2(DebounceCycles + 1);
  localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(DebounceCycles - 1);

  logic [SyncStages-1:0][NumInputs-1:0] sync_ff;
  logic [NumInputs-1:0]                 sync;
  logic [NumInputs-1:0][CntWidth-1:0]   cnt;
  logic [NumInputs-1:0][CntWidth-1:0]   cnt_nxt;
  logic [NumInputs-1:0]                 stable_nxt;
  logic [NumInputs-1:0]                 rise_nxt;
  logic [NumInputs-1:0]                 fall_nxt;
  logic                                 bypass_q;
  logic                                 bypass_edge;

  assign sync        = sync_ff[SyncStages-1];
  assign bypass_edge = bypass_i ^ bypass_q;

  // Stage 0 samples the pin; the last stage is the only one the filter may look at.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= {SyncStages{ResetValue}};
    end else begin
      sync_ff <= {sync_ff[SyncStages-2:0], raw_i};
    end
  end

  always_comb begin
    cnt_nxt    = cnt;
    stable_nxt = stable_o;
    rise_nxt   = '0;
    fall_nxt   = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (bypass_edge) begin
        // A mode change only flushes partial counts; the accepted level is kept.
        cnt_nxt[i] = '0;
      end else if (bypass_i) begin
        cnt_nxt[i]    = '0;
        stable_nxt[i] = sync[i];
      end else if (sync[i] == stable_o[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CntMax) begin
        cnt_nxt[i]    = '0;
        stable_nxt[i] = sync[i];
      end else begin
        cnt_nxt[i] = cnt[i] + CntWidth'(1);
      end
      rise_nxt[i] = stable_nxt[i] & ~stable_o[i];
      fall_nxt[i] = ~stable_nxt[i] & stable_o[i];
    end
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      stable_o  <= ResetValue;
      rise_o    <= '0;
      fall_o    <= '0;
      changed_o <= 1'b0;
      bypass_q  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      stable_o  <= stable_nxt;
      rise_o    <= rise_nxt;
      fall_o    <= fall_nxt;
      changed_o <= |(rise_nxt | fall_nxt);
      bypass_q  <= bypass_i;
    end
  end

endmodule
